// File: rtl/life_pkg.sv
// life_pkg: shared state encoding, neighbour offset table and default grid/colour constants.
package life_pkg;
  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 12;
  localparam logic [2:0] ALIVE_COLOUR_DEF = 3'b111;
  localparam logic [2:0] DEAD_COLOUR_DEF = 3'b000;
  typedef enum logic [2:0] {IDLE, READ, READ_LAST, WRITE, PLOT, NEXT, SWAP, DONE} state_t;
  typedef enum logic [1:0] {D_ZERO, D_NEG, D_POS} off_t;
  // k0 is the cell itself; k1..k8 walk the 3x3 ring in raster order
  function automatic off_t nbr_dx(input logic [3:0] k);
    return (k == 4'd1 || k == 4'd4 || k == 4'd6) ? D_NEG :
           (k == 4'd3 || k == 4'd5 || k == 4'd8) ? D_POS : D_ZERO;
  endfunction
  function automatic off_t nbr_dy(input logic [3:0] k);
    return (k >= 4'd1 && k <= 4'd3) ? D_NEG :
           (k >= 4'd6 && k <= 4'd8) ? D_POS : D_ZERO;
  endfunction
endpackage

// File: rtl/life_nbr_addr.sv
// life_nbr_addr: toroidally wrapped read address of neighbour k around cell (x, y).
module life_nbr_addr import life_pkg::*; #(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int X_W = 4,
  parameter int Y_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr
);
  off_t dx, dy;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  always_comb begin
    dx = nbr_dx(k);
    dy = nbr_dy(k);
    nx = dx == D_NEG ? (x == '0 ? X_W'(GRID_W - 1) : x - X_W'(1)) :
         dx == D_POS ? (x == X_W'(GRID_W - 1) ? '0 : x + X_W'(1)) : x;
    ny = dy == D_NEG ? (y == '0 ? Y_W'(GRID_H - 1) : y - Y_W'(1)) :
         dy == D_POS ? (y == Y_W'(GRID_H - 1) ? '0 : y + Y_W'(1)) : y;
    addr = ADDR_W'(ny) * ADDR_W'(GRID_W) + ADDR_W'(nx);
  end
endmodule

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: sequences one Game-of-Life generation (read 9 cells, write, plot per cell, then swap buffers).
module life_gen_ctrl import life_pkg::*; #(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int X_W = 4,
  parameter int Y_W = 4,
  parameter int ADDR_W = 8,
  parameter logic [2:0] ALIVE_COLOUR = ALIVE_COLOUR_DEF,
  parameter logic [2:0] DEAD_COLOUR = DEAD_COLOUR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              plot_req,
  input  logic              plot_ack,
  output logic [X_W-1:0]    plot_x,
  output logic [Y_W-1:0]    plot_y,
  output logic [2:0]        plot_colour,
  output logic              swap,
  output logic [15:0]       gen_count
);
  state_t state, state_n;
  logic [X_W-1:0] x, x_n;
  logic [Y_W-1:0] y, y_n;
  logic [3:0] k, k_n, n, n_n;
  logic self_r, self_n, live, x_last, last;
  logic [2:0] colour_n;
  logic [15:0] gen_n;
  logic [ADDR_W-1:0] nbr;

  life_nbr_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W))
    u_nbr (.x(x), .y(y), .k(k), .addr(nbr));

  assign live = (n == 4'd3) | (self_r & (n == 4'd2));
  assign x_last = x == X_W'(GRID_W - 1);
  assign last = x_last && y == Y_W'(GRID_H - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign swap = state == SWAP;
  assign wr_en = state == WRITE;
  assign plot_req = state == PLOT;
  assign rd_addr = state == READ ? nbr : '0;
  assign wr_addr = ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
  assign wr_data = wr_en & live;
  assign plot_x = x;
  assign plot_y = y;

  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    k_n = k;
    n_n = n;
    self_n = self_r;
    colour_n = plot_colour;
    gen_n = gen_count;
    case (state)
      IDLE: if (start) begin
        state_n = READ;
        x_n = '0;
        y_n = '0;
        k_n = '0;
        n_n = '0;
      end
      // rd_data lags rd_addr by one cycle, so step k captures neighbour k-1
      READ: begin
        self_n = k == 4'd1 ? rd_data : self_r;
        n_n = k >= 4'd2 ? n + 4'(rd_data) : n;
        k_n = k + 4'd1;
        state_n = k == 4'd8 ? READ_LAST : READ;
      end
      READ_LAST: begin
        n_n = n + 4'(rd_data);
        state_n = WRITE;
      end
      WRITE: begin
        colour_n = live ? ALIVE_COLOUR : DEAD_COLOUR;
        state_n = PLOT;
      end
      PLOT: state_n = plot_ack ? NEXT : PLOT;
      NEXT: begin
        x_n = x_last ? '0 : x + X_W'(1);
        y_n = x_last ? (last ? '0 : y + Y_W'(1)) : y;
        k_n = '0;
        n_n = '0;
        state_n = last ? SWAP : READ;
      end
      SWAP: begin
        gen_n = gen_count + 16'd1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      k <= '0;
      n <= '0;
      self_r <= 1'b0;
      plot_colour <= '0;
      gen_count <= '0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      k <= k_n;
      n <= n_n;
      self_r <= self_n;
      plot_colour <= colour_n;
      gen_count <= gen_n;
    end
  end
endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: scoreboard bench for life_gen_ctrl on a 5x5 torus with a double-buffered cell RAM model.
module tb_life_gen_ctrl;
  localparam int W = 5;
  localparam int H = 5;
  logic clock = 1'b0;
  logic reset, start, rd_data, plot_ack;
  logic busy, done, wr_en, wr_data, plot_req, swap;
  logic [4:0] rd_addr, wr_addr;
  logic [2:0] plot_x, plot_y, plot_colour;
  logic [15:0] gen_count;
  logic [24:0] bufs [2];
  logic sel = 1'b0;
  logic ld;
  logic [24:0] ld_grid, g;
  logic [5:0] exp_wr [$];
  logic [8:0] exp_pl [$];
  logic [2:0] exp_col0;
  int n_cmp = 0, n_bad = 0, n_wr, n_pl, n_sw, cs, cd, ci;

  life_gen_ctrl #(.GRID_W(W), .GRID_H(H), .X_W(3), .Y_W(3), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .plot_req(plot_req), .plot_ack(plot_ack), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .swap(swap), .gen_count(gen_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ld) bufs[sel] <= ld_grid;
    else if (wr_en) bufs[~sel][wr_addr] <= wr_data;
    if (swap) sel <= ~sel;
    rd_data <= bufs[sel][rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {busy, done, wr_en, swap, plot_req, rd_addr, wr_addr, wr_data,
            plot_x, plot_y, plot_colour, gen_count};
  endfunction

  function automatic void push_expected(input logic [24:0] grid);
    int cnt;
    logic live;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) cnt += int'(grid[((yy + dy + H) % H) * W + (xx + dx + W) % W]);
        live = cnt == 3 || (grid[yy * W + xx] && cnt == 2);
        exp_wr.push_back({5'(yy * W + xx), live});
        exp_pl.push_back({3'(xx), 3'(yy), live ? 3'b111 : 3'b000});
        if (xx == 0 && yy == 0) exp_col0 = live ? 3'b111 : 3'b000;
      end
  endfunction

  task automatic load(input logic [24:0] grid);
    ld_grid = grid;
    ld = 1'b1;
    @(negedge clock);
    ld = 1'b0;
  endtask

  task automatic run_gen(input int stall, input int abort_at, output int c_swap, output int c_done, output int c_idle);
    int sl;
    logic [4:0] rd_first;
    bit ended;
    c_swap = -1; c_done = -1; c_idle = -1;
    n_wr = 0; n_pl = 0; n_sw = 0;
    sl = stall; rd_first = '0; ended = 0;
    push_expected(bufs[sel]);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_rise", busy, 1);
    for (int c = 0; c < 2000; c++) begin
      if (c == abort_at) return;
      start = c == 50;
      if (plot_req && plot_x == 0 && plot_y == 0 && sl > 0) begin
        if (sl == stall) rd_first = rd_addr;
        check("stall_stable", {plot_req, plot_x, plot_y, plot_colour, rd_addr},
              {1'b1, 3'd0, 3'd0, exp_col0, rd_first});
        plot_ack = 1'b0;
        sl--;
      end else plot_ack = 1'b1;
      if (wr_en) begin
        n_wr++;
        if (exp_wr.size() == 0) check("wr_extra", 1, 0);
        else check("wr", {wr_addr, wr_data}, exp_wr.pop_front());
      end
      if (plot_req && plot_ack) begin
        n_pl++;
        if (exp_pl.size() == 0) check("plot_extra", 1, 0);
        else check("plot", {plot_x, plot_y, plot_colour}, exp_pl.pop_front());
      end
      if (swap) begin n_sw++; c_swap = c; end
      if (done) c_done = c;
      if (!busy) begin c_idle = c; ended = 1; break; end
      @(negedge clock);
    end
    start = 1'b0;
    plot_ack = 1'b1;
    if (!ended) check("timeout", 1, 0);
  endtask

  task automatic finish_checks(input string tag);
    check({tag, "_writes"}, n_wr, 25);
    check({tag, "_plots"}, n_pl, 25);
    check({tag, "_swaps"}, n_sw, 1);
    check({tag, "_left"}, exp_wr.size() + exp_pl.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; plot_ack = 1'b1; ld = 1'b0; ld_grid = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", busy, 0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check("reset_idle_zero", outs(), 0);
    @(negedge clock);
    reset = 1'b0;

    g = '0; g[7] = 1'b1; g[12] = 1'b1; g[17] = 1'b1;
    load(g);
    run_gen(0, -1, cs, cd, ci);
    finish_checks("blink");
    check("blink_swap_cyc", cs, 325);
    check("blink_done_cyc", cd, 326);
    check("blink_idle_cyc", ci, 327);
    check("blink_gen", gen_count, 1);
    check("blink_result", bufs[sel], 25'h0003800);

    g = '0; g[24] = 1'b1; g[20] = 1'b1; g[4] = 1'b1;
    load(g);
    run_gen(0, -1, cs, cd, ci);
    finish_checks("torus");
    check("torus_0_0", bufs[sel][0], 1);
    check("torus_4_4", bufs[sel][24], 1);
    check("torus_gen", gen_count, 2);

    g = '0; g[7] = 1'b1; g[12] = 1'b1; g[17] = 1'b1;
    load(g);
    run_gen(10, -1, cs, cd, ci);
    finish_checks("stall");
    check("stall_done_cyc", cd, 336);
    check("stall_gen", gen_count, 3);

    load(g);
    run_gen(0, 96, cs, cd, ci);
    reset = 1'b1;
    #1 check("reset_run_zero", outs(), 0);
    repeat (3) begin
      @(negedge clock);
      check("abort_no_swap", swap, 0);
    end
    check("abort_swaps", n_sw, 0);
    check("abort_gen", gen_count, 0);
    exp_wr.delete();
    exp_pl.delete();
    reset = 1'b0;
    load(g);
    run_gen(0, -1, cs, cd, ci);
    finish_checks("fresh");
    check("fresh_done_cyc", cd, 326);
    check("fresh_gen", gen_count, 1);
    check("fresh_result", bufs[sel], 25'h0003800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
